debug_uart_tx: RTL and testbench

- 8N1 UART transmitter for the debug serial path.
- Protocol counterpart of debug_uart_rx: same tick-based bit timing and LSB-first framing, so one TICKS_PER_BIT value drives both ends of a link.
- Has a one-byte holding register in front of the shifter, so back-to-back bytes go out with no idle gap between stop bit and next start bit.
- Sits between debug/status logic (byte producer) and the FPGA TX pin.

---
 rtl/debug_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_debug_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
// Define DEBUG_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module debug_uart_tx #(
  parameter int TICKS_PER_BIT      = 32,
  parameter int TICKS_PER_BIT_SIZE = 6
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic [7:0] i_txdata,
  input  logic       i_txstart,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

`ifdef DEBUG_UART_TX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;
`endif

  localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_LAST = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);

  state_t                        r_state;
  state_t                        w_nextState;
  logic [TICKS_PER_BIT_SIZE-1:0] r_tick;
  logic [2:0]                    r_bitCnt;
  logic [7:0]                    r_shift;
  logic [7:0]                    r_hold;
  logic                          r_holdValid;
  logic                          r_ready;
  logic                          r_tx;
  logic                          r_done;
`ifdef DEBUG_UART_TX_PARITY_EN
  logic                          r_parity;
`endif

  logic w_tickWrap;
  logic w_accept;
  logic w_load;
  logic w_shiftEn;
  logic w_frameDone;
  logic w_txNext;

  assign w_tickWrap = (r_tick == TICK_LAST);
  // Accept needs r_ready and load needs r_holdValid, so the two never coincide.
  assign w_accept   = i_txstart & r_ready & i_enable;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_shiftEn   = 1'b0;
    w_frameDone = 1'b0;
    w_txNext    = r_tx;
    case (r_state)
      IDLE: begin
        w_txNext = 1'b1;
        if (r_holdValid) begin
          w_nextState = START;
          w_load      = 1'b1;
          w_txNext    = 1'b0;
        end
      end
      START: begin
        if (w_tickWrap) begin
          w_nextState = DATA;
          w_txNext    = r_shift[0];
        end
      end
      DATA: begin
        if (w_tickWrap) begin
          if (r_bitCnt == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
            w_nextState = PARITY;
            w_txNext    = r_parity;
`else
            w_nextState = STOP;
            w_txNext    = 1'b1;
`endif
          end else begin
            w_shiftEn = 1'b1;
            w_txNext  = r_shift[1];
          end
        end
      end
`ifdef DEBUG_UART_TX_PARITY_EN
      PARITY: begin
        if (w_tickWrap) begin
          w_nextState = STOP;
          w_txNext    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_tickWrap) begin
          w_frameDone = 1'b1;
          // A waiting byte starts immediately, so no idle bit separates the frames.
          if (r_holdValid) begin
            w_nextState = START;
            w_load      = 1'b1;
            w_txNext    = 1'b0;
          end else begin
            w_nextState = IDLE;
            w_txNext    = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_txNext    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_tick      <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_holdValid <= 1'b0;
      r_ready     <= 1'b1;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_tx   <= w_txNext;
      r_done <= w_frameDone;

      if ((r_state == IDLE) || w_tickWrap) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + TICKS_PER_BIT_SIZE'(1);
      end

      if (w_load) begin
        r_shift  <= r_hold;
        r_bitCnt <= '0;
`ifdef DEBUG_UART_TX_PARITY_EN
        r_parity <= ^r_hold;
`endif
      end else if (w_shiftEn) begin
        r_shift  <= {1'b0, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 3'd1;
      end

      if (w_accept) begin
        r_hold      <= i_txdata;
        r_holdValid <= 1'b1;
        r_ready     <= 1'b0;
      end else if (w_load) begin
        r_holdValid <= 1'b0;
        r_ready     <= 1'b1;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_busy  = (r_state != IDLE) | r_holdValid;
  assign o_done  = r_done;
  assign o_tx    = r_tx;

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: table-driven frame checks plus directed back-to-back, drop, enable and reset sequences.
// Frames are decoded cycle by cycle against hand-written bit patterns; parity builds append the table parity bit.
module tb_debug_uart_tx;
  localparam int T   = 4;
  localparam int TSZ = 3;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       i_clk     = 1'b0;
  logic       reset     = 1'b1;
  logic       i_enable  = 1'b1;
  logic [7:0] i_txdata  = 8'h00;
  logic       i_txstart = 1'b0;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_tx;

  int checks = 0;
  int errors = 0;

  // frame: start bit first (bit 9), data LSB first, stop bit last (bit 0)
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       parity;
  } vec_t;

  vec_t vecs[5];

  debug_uart_tx #(
    .TICKS_PER_BIT     (T),
    .TICKS_PER_BIT_SIZE(TSZ)
  ) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_enable (i_enable),
    .i_txdata (i_txdata),
    .i_txstart(i_txstart),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_tx     (o_tx)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    i_txdata  = data;
    i_txstart = 1'b1;
    tick();
    i_txstart = 1'b0;
  endtask

  function automatic logic [10:0] buildFrame(input logic [9:0] f, input logic p);
`ifdef DEBUG_UART_TX_PARITY_EN
    return {f[9:1], p, 1'b1};
`else
    return {1'b0, f};
`endif
  endfunction

  // Called at cycle 0 of a frame (just after the start-bit fall); returns just after the edge leaving STOP.
  task automatic checkFrame(input logic [9:0] f, input logic p, input string name);
    logic [10:0] expFrame;
    logic [10:0] obs;
    int          cycErr  = 0;
    int          doneErr = 0;
    expFrame = buildFrame(f, p);
    obs      = '0;
    for (int c = 0; c < NB * T; c++) begin
      if (o_tx !== expFrame[NB - 1 - c / T]) cycErr++;
      if (c % T == T / 2) obs[NB - 1 - c / T] = o_tx;
      if (c > 0 && o_done !== 1'b0) doneErr++;
      tick();
    end
    checkOutput({name, "_bits"}, 32'(obs), 32'(expFrame));
    checkOutput({name, "_bitTiming"}, cycErr, 0);
    checkOutput({name, "_doneEarly"}, doneErr, 0);
    checkOutput({name, "_donePulse"}, 32'(o_done), 32'd1);
  endtask

  initial begin
    int bad;

    vecs[0] = '{data: 8'hA5, frame: 10'b0_10100101_1, parity: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'b0_00000000_1, parity: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b0_11111111_1, parity: 1'b0};
    vecs[3] = '{data: 8'h3C, frame: 10'b0_00111100_1, parity: 1'b0};
    vecs[4] = '{data: 8'h07, frame: 10'b0_11100000_1, parity: 1'b1};

    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_tx", 32'(o_tx), 32'd1);
    checkOutput("reset_ready", 32'(o_ready), 32'd1);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_done", 32'(o_done), 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("v%0d_readyAfterAccept", i), 32'(o_ready), 32'd0);
      checkOutput($sformatf("v%0d_busyAfterAccept", i), 32'(o_busy), 32'd1);
      checkOutput($sformatf("v%0d_txBeforeFall", i), 32'(o_tx), 32'd1);
      tick();
      checkOutput($sformatf("v%0d_fallLatency", i), 32'(o_tx), 32'd0);
      checkOutput($sformatf("v%0d_readyAfterLoad", i), 32'(o_ready), 32'd1);
      checkFrame(vecs[i].frame, vecs[i].parity, $sformatf("v%0d", i));
      checkOutput($sformatf("v%0d_busyIdle", i), 32'(o_busy), 32'd0);
      tick();
      checkOutput($sformatf("v%0d_doneOneCycle", i), 32'(o_done), 32'd0);
      checkOutput($sformatf("v%0d_txIdle", i), 32'(o_tx), 32'd1);
    end

    // Back-to-back: second byte written the cycle o_ready rises
    applyStimulus(8'h55);
    tick();
    checkOutput("b2b_fall55", 32'(o_tx), 32'd0);
    fork
      checkFrame(10'b0_10101010_1, 1'b0, "b2b_55");
      begin
        applyStimulus(8'h0F);
        checkOutput("b2b_holdFull", 32'(o_ready), 32'd0);
        checkOutput("b2b_busy", 32'(o_busy), 32'd1);
      end
    join
    checkFrame(10'b0_11110000_1, 1'b0, "b2b_0F");
    checkOutput("b2b_busyIdle", 32'(o_busy), 32'd0);
    tick();
    checkOutput("b2b_doneOneCycle", 32'(o_done), 32'd0);

    // Third write while the holding register is full must be dropped
    applyStimulus(8'h11);
    tick();
    checkOutput("ign_fall11", 32'(o_tx), 32'd0);
    fork
      checkFrame(10'b0_10001000_1, 1'b0, "ign_11");
      begin
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        checkOutput("ign_readyLow", 32'(o_ready), 32'd0);
      end
    join
    checkFrame(10'b0_01000100_1, 1'b0, "ign_22");
    checkOutput("ign_busyIdle", 32'(o_busy), 32'd0);
    bad = 0;
    for (int c = 0; c < 3 * T * NB; c++) begin
      tick();
      if (o_tx !== 1'b1 || o_done !== 1'b0 && c > 0) bad++;
    end
    checkOutput("ign_noThirdFrame", bad, 0);

    // Disabled: strobe ignored entirely
    i_enable  = 1'b0;
    i_txdata  = 8'h77;
    i_txstart = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_ready !== 1'b1 || o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    checkOutput("en_disabledIgnored", bad, 0);
    i_txstart = 1'b0;
    i_enable  = 1'b1;
    tick();

    // Enable dropped mid-frame: frame still completes
    applyStimulus(8'hC3);
    tick();
    checkOutput("en_fallC3", 32'(o_tx), 32'd0);
    i_enable = 1'b0;
    checkFrame(10'b0_11000011_1, 1'b0, "en_C3");
    i_enable = 1'b1;
    tick();

    // Reset during data bit 3 with a byte held
    applyStimulus(8'hFF);
    tick();
    checkOutput("rst_fallFF", 32'(o_tx), 32'd0);
    applyStimulus(8'h01);
    checkOutput("rst_held", 32'(o_ready), 32'd0);
    for (int c = 0; c < 4 * T; c++) tick();
    checkOutput("rst_midData", 32'(o_tx), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rst_tx", 32'(o_tx), 32'd1);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 12 * T; c++) begin
      tick();
      if (o_tx !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    checkOutput("rst_heldDiscarded", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
